// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl: EX-stage operand forwarding selects, load-use stall/bubble,
// data-memory freeze, stall statistics and memory-wait watchdog.  Rev 1.0
`default_nettype none

module fwd_hazard_ctrl #(
    parameter int MAX_WAIT = 255,
    parameter int CNT_W    = 32
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             en,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic [4:0]       ex_rs,
    input  logic [4:0]       ex_rt,
    input  logic [4:0]       ex_rd,
    input  logic             ex_regwrite,
    input  logic             ex_memread,
    input  logic             mem_ready,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             stall_if_id,
    output logic             bubble_ex,
    output logic             freeze,
    output logic [CNT_W-1:0] lu_stall_cnt,
    output logic [CNT_W-1:0] mem_wait_cnt,
    output logic             mem_timeout
);

    localparam int               WAIT_W   = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    logic [4:0]        r_mem_rd;
    logic              r_mem_regwrite;
    logic              r_mem_memread;
    logic [4:0]        r_wb_rd;
    logic              r_wb_regwrite;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [WAIT_W-1:0] w_wait_inc;
    logic [CNT_W-1:0]  r_lu_cnt;
    logic [CNT_W-1:0]  r_mw_cnt;
    logic              r_timeout;
    logic              w_advance;
    logic              w_lu;

    // EX/MEM wins over MEM/WB because it holds the younger result.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic [4:0] m_rd,
        input logic       m_we,
        input logic [4:0] w_rd,
        input logic       w_we
    );
        if (m_we && (m_rd != 5'd0) && (m_rd == src))
            return 2'b10;
        else if (w_we && (w_rd != 5'd0) && (w_rd == src))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign fwd_a = fwd_sel(ex_rs, r_mem_rd, r_mem_regwrite, r_wb_rd, r_wb_regwrite);
    assign fwd_b = fwd_sel(ex_rt, r_mem_rd, r_mem_regwrite, r_wb_rd, r_wb_regwrite);

    assign freeze      = r_mem_memread & ~mem_ready;
    assign w_advance   = en & ~freeze;
    assign w_lu        = id_valid & ex_memread & (ex_rd != 5'd0) &
                         ((ex_rd == id_rs) | (ex_rd == id_rt));
    assign stall_if_id = w_lu | freeze;
    assign bubble_ex   = w_lu & ~freeze;
    assign w_wait_inc  = r_wait_cnt + WAIT_W'(1);

    assign lu_stall_cnt = r_lu_cnt;
    assign mem_wait_cnt = r_mw_cnt;
    assign mem_timeout  = r_timeout;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_mem_rd       <= 5'd0;
            r_mem_regwrite <= 1'b0;
            r_mem_memread  <= 1'b0;
            r_wb_rd        <= 5'd0;
            r_wb_regwrite  <= 1'b0;
        end else if (w_advance) begin
            r_mem_rd       <= ex_rd;
            r_mem_regwrite <= ex_regwrite;
            r_mem_memread  <= ex_memread;
            r_wb_rd        <= r_mem_rd;
            r_wb_regwrite  <= r_mem_regwrite;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_lu_cnt <= '0;
            r_mw_cnt <= '0;
        end else if (en) begin
            if (bubble_ex && (r_lu_cnt != '1))
                r_lu_cnt <= r_lu_cnt + CNT_W'(1);
            if (freeze && (r_mw_cnt != '1))
                r_mw_cnt <= r_mw_cnt + CNT_W'(1);
        end
    end

    // Timeout is raised on the same edge the wait count lands on MAX_WAIT.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_wait_cnt <= '0;
            r_timeout  <= 1'b0;
        end else if (en) begin
            if (!freeze) begin
                r_wait_cnt <= '0;
            end else if (r_wait_cnt != WAIT_MAX) begin
                r_wait_cnt <= w_wait_inc;
                if (w_wait_inc == WAIT_MAX)
                    r_timeout <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fwd_hazard_ctrl.sv
// tb_fwd_hazard_ctrl: directed self-checking bench for fwd_hazard_ctrl.  Rev 1.0
`default_nettype none

module tb_fwd_hazard_ctrl;

    logic       Clk = 1'b0;
    logic       Rst_n;
    logic       en, id_valid, ex_regwrite, ex_memread, mem_ready;
    logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd;
    logic [1:0] fwd_a, fwd_b;
    logic       stall_if_id, bubble_ex, freeze, mem_timeout;
    logic [3:0] lu_stall_cnt, mem_wait_cnt;

    int errors = 0;
    int checks = 0;

    fwd_hazard_ctrl #(.MAX_WAIT(3), .CNT_W(4)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .en(en), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .mem_ready(mem_ready), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .stall_if_id(stall_if_id), .bubble_ex(bubble_ex), .freeze(freeze),
        .lu_stall_cnt(lu_stall_cnt), .mem_wait_cnt(mem_wait_cnt),
        .mem_timeout(mem_timeout)
    );

    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_inputs();
        en = 1'b1; id_valid = 1'b0; id_rs = 5'd0; id_rt = 5'd0;
        ex_rs = 5'd0; ex_rt = 5'd0; ex_rd = 5'd0;
        ex_regwrite = 1'b0; ex_memread = 1'b0; mem_ready = 1'b1;
    endtask

    task automatic test_reset_init();
        Rst_n = 1'b0;
        idle_inputs();
        #12;
        checks++; if (fwd_a !== 2'b00) begin errors++; $display("FAIL init_fwd_a: got %b want 00", fwd_a); end
        checks++; if (fwd_b !== 2'b00) begin errors++; $display("FAIL init_fwd_b: got %b want 00", fwd_b); end
        checks++; if ({stall_if_id, bubble_ex, freeze} !== 3'b000) begin errors++; $display("FAIL init_ctrl: got %b want 000", {stall_if_id, bubble_ex, freeze}); end
        checks++; if (lu_stall_cnt !== 4'd0 || mem_wait_cnt !== 4'd0) begin errors++; $display("FAIL init_cnt: got %0d/%0d want 0/0", lu_stall_cnt, mem_wait_cnt); end
        checks++; if (mem_timeout !== 1'b0) begin errors++; $display("FAIL init_timeout: got %b want 0", mem_timeout); end
        step();
        Rst_n = 1'b1;
    endtask

    task automatic test_ex_fwd();
        ex_rd = 5'd3; ex_regwrite = 1'b1;
        step();
        ex_rs = 5'd3; ex_rt = 5'd0;
        #1;
        checks++; if (fwd_a !== 2'b10) begin errors++; $display("FAIL ex_fwd_a: got %b want 10", fwd_a); end
        checks++; if (fwd_b !== 2'b00) begin errors++; $display("FAIL ex_fwd_b_zero: got %b want 00", fwd_b); end
        step();
        #1;
        checks++; if (fwd_a !== 2'b10) begin errors++; $display("FAIL ex_fwd_priority: got %b want 10", fwd_a); end
        ex_rd = 5'd0;
        step();
        step();
        ex_rs = 5'd0;
        #1;
        checks++; if (fwd_a !== 2'b00) begin errors++; $display("FAIL ex_fwd_r0: got %b want 00", fwd_a); end
    endtask

    task automatic test_wb_fwd();
        ex_rd = 5'd5; ex_regwrite = 1'b1;
        step();
        ex_rd = 5'd6;
        step();
        ex_rs = 5'd7; ex_rt = 5'd5;
        #1;
        checks++; if (fwd_b !== 2'b01) begin errors++; $display("FAIL wb_fwd_b: got %b want 01", fwd_b); end
        checks++; if (fwd_a !== 2'b00) begin errors++; $display("FAIL wb_fwd_a: got %b want 00", fwd_a); end
        ex_rs = 5'd6;
        #1;
        checks++; if ({fwd_a, fwd_b} !== 4'b1001) begin errors++; $display("FAIL mixed_fwd: got %b want 1001", {fwd_a, fwd_b}); end
        ex_rd = 5'd9; ex_regwrite = 1'b0;
        step();
        ex_rs = 5'd9; ex_rt = 5'd0;
        #1;
        checks++; if (fwd_a !== 2'b00) begin errors++; $display("FAIL no_regwrite_fwd: got %b want 00", fwd_a); end
    endtask

    task automatic test_load_use();
        ex_memread = 1'b1; ex_rd = 5'd8; ex_regwrite = 1'b1;
        id_valid = 1'b1; id_rs = 5'd8; id_rt = 5'd0; ex_rs = 5'd0;
        #1;
        checks++; if ({stall_if_id, bubble_ex} !== 2'b11) begin errors++; $display("FAIL lu_detect: got %b want 11", {stall_if_id, bubble_ex}); end
        step();
        ex_memread = 1'b0; ex_rd = 5'd0; ex_regwrite = 1'b0;
        #1;
        checks++; if (lu_stall_cnt !== 4'd1) begin errors++; $display("FAIL lu_cnt: got %0d want 1", lu_stall_cnt); end
        checks++; if ({stall_if_id, bubble_ex, freeze} !== 3'b000) begin errors++; $display("FAIL lu_one_cycle: got %b want 000", {stall_if_id, bubble_ex, freeze}); end
        step();
        id_valid = 1'b0; ex_rs = 5'd8;
        #1;
        checks++; if (fwd_a !== 2'b01) begin errors++; $display("FAIL lu_fwd_a: got %b want 01", fwd_a); end
        checks++; if (lu_stall_cnt !== 4'd1) begin errors++; $display("FAIL lu_cnt_hold: got %0d want 1", lu_stall_cnt); end
    endtask

    task automatic test_mem_wait();
        ex_memread = 1'b1; ex_rd = 5'd10; ex_regwrite = 1'b1; mem_ready = 1'b1;
        step();
        ex_rd = 5'd11; id_valid = 1'b1; id_rs = 5'd11; ex_rs = 5'd10;
        mem_ready = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++; if ({freeze, stall_if_id, bubble_ex} !== 3'b110) begin errors++; $display("FAIL wait_ctrl[%0d]: got %b want 110", i, {freeze, stall_if_id, bubble_ex}); end
            checks++; if (fwd_a !== 2'b10) begin errors++; $display("FAIL wait_shadow[%0d]: got %b want 10", i, fwd_a); end
            step();
        end
        checks++; if (mem_wait_cnt !== 4'd4) begin errors++; $display("FAIL wait_cnt: got %0d want 4", mem_wait_cnt); end
        checks++; if (lu_stall_cnt !== 4'd1) begin errors++; $display("FAIL wait_lu_cnt: got %0d want 1", lu_stall_cnt); end
        mem_ready = 1'b1;
        #1;
        checks++; if ({freeze, bubble_ex} !== 2'b01) begin errors++; $display("FAIL wait_release: got %b want 01", {freeze, bubble_ex}); end
        step();
        checks++; if (fwd_a !== 2'b01) begin errors++; $display("FAIL wait_resume_fwd: got %b want 01", fwd_a); end
        checks++; if (lu_stall_cnt !== 4'd2) begin errors++; $display("FAIL wait_lu_cnt2: got %0d want 2", lu_stall_cnt); end
    endtask

    task automatic test_reset_mid();
        id_valid = 1'b0; ex_memread = 1'b0;
        ex_rs = 5'd11; ex_rt = 5'd10; mem_ready = 1'b0;
        #1;
        checks++; if ({fwd_a, fwd_b, freeze} !== 5'b10011) begin errors++; $display("FAIL prereset_state: got %b want 10011", {fwd_a, fwd_b, freeze}); end
        Rst_n = 1'b0;
        #1;
        checks++; if ({fwd_a, fwd_b} !== 4'b0000) begin errors++; $display("FAIL rst_fwd: got %b want 0000", {fwd_a, fwd_b}); end
        checks++; if ({stall_if_id, bubble_ex, freeze} !== 3'b000) begin errors++; $display("FAIL rst_ctrl: got %b want 000", {stall_if_id, bubble_ex, freeze}); end
        checks++; if (lu_stall_cnt !== 4'd0 || mem_wait_cnt !== 4'd0) begin errors++; $display("FAIL rst_cnt: got %0d/%0d want 0/0", lu_stall_cnt, mem_wait_cnt); end
        #2;
        Rst_n = 1'b1;
        idle_inputs();
    endtask

    task automatic test_timeout();
        ex_memread = 1'b1; ex_rd = 5'd12; ex_regwrite = 1'b1;
        step();
        en = 1'b0; mem_ready = 1'b0;
        #1;
        checks++; if (freeze !== 1'b1) begin errors++; $display("FAIL freeze_no_en: got %b want 1", freeze); end
        repeat (5) step();
        checks++; if (mem_timeout !== 1'b0 || mem_wait_cnt !== 4'd0) begin errors++; $display("FAIL to_en0: got %b/%0d want 0/0", mem_timeout, mem_wait_cnt); end
        en = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step();
            checks++; if (mem_timeout !== (i >= 3)) begin errors++; $display("FAIL to_edge[%0d]: got %b want %b", i, mem_timeout, (i >= 3)); end
        end
        checks++; if (mem_wait_cnt !== 4'd5) begin errors++; $display("FAIL to_wait_cnt: got %0d want 5", mem_wait_cnt); end
        mem_ready = 1'b1;
        #1;
        checks++; if ({freeze, mem_timeout} !== 2'b01) begin errors++; $display("FAIL to_sticky: got %b want 01", {freeze, mem_timeout}); end
        step();
        mem_ready = 1'b0;
        repeat (12) step();
        checks++; if (mem_wait_cnt !== 4'd15) begin errors++; $display("FAIL wait_sat: got %0d want 15", mem_wait_cnt); end
        checks++; if (mem_timeout !== 1'b1 || lu_stall_cnt !== 4'd0) begin errors++; $display("FAIL to_final: got %b/%0d want 1/0", mem_timeout, lu_stall_cnt); end
    endtask

    initial begin
        test_reset_init();
        test_ex_fwd();
        test_wb_fwd();
        test_load_use();
        test_mem_wait();
        test_reset_mid();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
